cdb_arbiter: RTL

Sequences functional-unit results onto the 3-wide complete/CDB path. Each FU has a one-entry output buffer. Each cycle the block grants up to `SUPERSCALAR_WAYS` occupied buffers in round-robin order, drives them as `FU_COMPLETE_PACKET` lanes into the complete stage, and back-pressures FUs that lost arbitration. It sits between the FU array and the complete stage and flushes on branch squash.

---
 rtl/cdb_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that moves functional-unit results from one-entry
// per-FU output buffers onto the WAYS-wide complete/CDB path.
package cdb_arbiter_pkg;
  typedef struct packed {
    logic        valid;
    logic        take_branch;
    logic [5:0]  pr_idx;
    logic [4:0]  rob_idx;
    logic [31:0] result;
  } FU_COMPLETE_PACKET;
endpackage

// One FU output buffer: refills when empty or when its entry leaves this cycle.
module cdb_fu_slot
  import cdb_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              squash_in,
  input  logic              granted,
  input  FU_COMPLETE_PACKET pkt_in,
  output FU_COMPLETE_PACKET buf_q
);
  always_ff @(posedge clock) begin
    if (reset)
      buf_q <= '0;
    else if (squash_in)
      buf_q <= '0;
    else if (pkt_in.valid && (!buf_q.valid || granted))
      buf_q <= pkt_in;
    else if (granted)
      buf_q <= '0;
  end
endmodule

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int NUM_FU = 8,
  parameter  int WAYS   = 3,
  localparam int PTR_W  = $clog2(NUM_FU),
  localparam int CNT_W  = $clog2(WAYS + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           squash_in,
  input  FU_COMPLETE_PACKET [NUM_FU-1:0] fu_packet_in,
  output logic              [NUM_FU-1:0] fu_stall_out,
  output FU_COMPLETE_PACKET [WAYS-1:0]   complete_fu_out,
  output logic              [CNT_W-1:0]  grant_count_out
);
  localparam logic [PTR_W:0]   FU_CNT  = (PTR_W + 1)'(NUM_FU);
  localparam logic [PTR_W-1:0] LAST_FU = PTR_W'(NUM_FU - 1);
  localparam logic [CNT_W-1:0] WAYS_C  = CNT_W'(WAYS);

  FU_COMPLETE_PACKET [NUM_FU-1:0] buf_q;
  logic [NUM_FU-1:0] occupied, granted;
  logic [PTR_W-1:0]  rr_ptr, last_idx, idx;
  logic [PTR_W:0]    idx_sum;
  logic [CNT_W-1:0]  cnt;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_slot
    cdb_fu_slot u_slot (
      .clock     (clock),
      .reset     (reset),
      .squash_in (squash_in),
      .granted   (granted[g]),
      .pkt_in    (fu_packet_in[g]),
      .buf_q     (buf_q[g])
    );
    assign occupied[g] = buf_q[g].valid;
  end

  // Scan from rr_ptr with an explicit modulo so NUM_FU need not be a power of two.
  always_comb begin
    complete_fu_out = '0;
    granted         = '0;
    cnt             = '0;
    last_idx        = '0;
    idx_sum         = '0;
    idx             = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx_sum = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (idx_sum >= FU_CNT) idx_sum = idx_sum - FU_CNT;
      idx = idx_sum[PTR_W-1:0];
      if (occupied[idx] && (cnt < WAYS_C)) begin
        complete_fu_out[cnt] = buf_q[idx];
        granted[idx]         = 1'b1;
        last_idx             = idx;
        cnt                  = cnt + CNT_W'(1);
      end
    end
  end

  assign grant_count_out = cnt;
  assign fu_stall_out    = occupied & ~granted & {NUM_FU{~squash_in}};

  // Pointer keeps advancing during squash; the complete stage drops those lanes.
  always_ff @(posedge clock) begin
    if (reset)
      rr_ptr <= '0;
    else if (cnt != '0)
      rr_ptr <= (last_idx == LAST_FU) ? '0 : last_idx + PTR_W'(1);
  end
endmodule
